// File: rtl/alu_arbiter.sv
// alu_arbiter: shares one external W-bit ALU (add/sub/and/orr) among NREQ
// requesters. Round-robin grant, one operation in flight, operands and result
// registered. Each op takes IDLE (accept) -> EXEC (ALU evaluates) -> RESP (hold
// result until the owner takes it), so at least 3 cycles per op.
//
// Ports:
//   clk, reset            clock (rising edge), synchronous active-high reset
//   req_valid/req_ready   per-requester request handshake (ready is combinational)
//   req_a/req_b/req_ctrl  packed per-requester operands; slice i = requester i
//   resp_valid/resp_ready per-requester response handshake
//   resp_out              shared result, qualified by resp_valid
//   alu_a/alu_b/alu_ctrl  to the ALU, driven only from registers
//   alu_out               from the ALU (combinational)
//   busy                  high whenever the FSM is not IDLE
//
// Optional statistics: define ALU_ARB_STATS_EN to add grant_cnt (16-bit
// saturating accept counter per requester) and stall_cnt (16-bit saturating
// count of cycles where someone is waiting and nobody is granted).

module alu_arbiter #(
    parameter int NREQ = 2,
    parameter int W    = 32
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [NREQ-1:0]      req_valid,
    output logic [NREQ-1:0]      req_ready,
    input  logic [NREQ*W-1:0]    req_a,
    input  logic [NREQ*W-1:0]    req_b,
    input  logic [NREQ*2-1:0]    req_ctrl,
    output logic [NREQ-1:0]      resp_valid,
    input  logic [NREQ-1:0]      resp_ready,
    output logic [W-1:0]         resp_out,
    output logic [W-1:0]         alu_a,
    output logic [W-1:0]         alu_b,
    output logic [1:0]           alu_ctrl,
    input  logic [W-1:0]         alu_out,
`ifdef ALU_ARB_STATS_EN
    output logic [NREQ*16-1:0]   grant_cnt,
    output logic [15:0]          stall_cnt,
`endif
    output logic                 busy
);

    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

    state_t          r_state;
    logic [PW-1:0]   r_ptr;
    logic [PW-1:0]   r_owner;
    logic [W-1:0]    r_op_a;
    logic [W-1:0]    r_op_b;
    logic [1:0]      r_op_ctrl;
    logic [W-1:0]    r_result;

    logic            w_gnt_vld;
    logic [PW-1:0]   w_gnt_idx;
    logic            w_accept;
    logic            w_resp_hs;

    // Round-robin search starting at r_ptr. Walking the offsets from the far
    // end toward zero lets the nearest valid requester overwrite later ones.
    always_comb begin
        w_gnt_vld = 1'b0;
        w_gnt_idx = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            int j;
            j = int'(r_ptr) + k;
            if (j >= NREQ) j = j - NREQ;
            if (req_valid[j]) begin
                w_gnt_vld = 1'b1;
                w_gnt_idx = PW'(j);
            end
        end
    end

    assign w_accept  = (r_state == IDLE) && w_gnt_vld;
    assign w_resp_hs = (r_state == RESP) && resp_ready[r_owner];

    always_comb begin
        req_ready = '0;
        if (w_accept) req_ready[w_gnt_idx] = 1'b1;
    end

    always_comb begin
        resp_valid = '0;
        if (r_state == RESP) resp_valid[r_owner] = 1'b1;
    end

    // ALU inputs come straight from the operand registers so unselected
    // requesters can never disturb them.
    assign alu_a    = r_op_a;
    assign alu_b    = r_op_b;
    assign alu_ctrl = r_op_ctrl;
    assign resp_out = r_result;
    assign busy     = (r_state != IDLE);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= IDLE;
            r_ptr     <= '0;
            r_owner   <= '0;
            r_op_a    <= '0;
            r_op_b    <= '0;
            r_op_ctrl <= 2'b00;
            r_result  <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_op_a    <= req_a[int'(w_gnt_idx)*W +: W];
                        r_op_b    <= req_b[int'(w_gnt_idx)*W +: W];
                        r_op_ctrl <= req_ctrl[int'(w_gnt_idx)*2 +: 2];
                        r_owner   <= w_gnt_idx;
                        r_state   <= EXEC;
                    end
                end
                EXEC: begin
                    r_result <= alu_out;
                    r_state  <= RESP;
                end
                RESP: begin
                    if (w_resp_hs) begin
                        r_ptr   <= (r_owner == PW'(NREQ - 1)) ? '0 : r_owner + PW'(1);
                        r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

`ifdef ALU_ARB_STATS_EN
    logic w_stall;
    assign w_stall = (|req_valid) && !(|req_ready);

    always_ff @(posedge clk) begin
        if (reset) begin
            grant_cnt <= '0;
            stall_cnt <= '0;
        end else begin
            if (w_accept && grant_cnt[int'(w_gnt_idx)*16 +: 16] != 16'hFFFF)
                grant_cnt[int'(w_gnt_idx)*16 +: 16] <= grant_cnt[int'(w_gnt_idx)*16 +: 16] + 16'd1;
            if (w_stall && stall_cnt != 16'hFFFF)
                stall_cnt <= stall_cnt + 16'd1;
        end
    end
`endif

endmodule
